instr_fetch_q: RTL and testbench

Parametrised instruction-fetch stage for the RV32 pipeline. Generates sequential PCs, issues pipelined requests to a handshaked instruction memory, and buffers returned words with their PCs in a small queue toward decode. It accepts branch redirects from the MEM stage and discards in-flight responses, and it stalls cleanly on decode back-pressure. It sits between the instruction memory and the IF/ID boundary.

---
 rtl/if_pkg.sv | 17 +
 rtl/if_entry_queue.sv | 86 ++++++++
 rtl/instr_fetch_q.sv | 134 +++++++++++++
 tb/tb_instr_fetch_q.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared types and constants for the instruction-fetch queue
package if_pkg;

    localparam int                  IF_XLEN   = 32;
    localparam logic [IF_XLEN-1:0]  NOP_INSTR = 32'h0000_0013;
    localparam int                  PC_STEP   = 4;

    // One fetch-queue slot. An entry is allocated (filled=0) when its
    // request is granted and becomes presentable once its word returns.
    typedef struct packed {
        logic [IF_XLEN-1:0] pc;
        logic [IF_XLEN-1:0] instr;
        logic               filled;
        logic               misalign;
    } if_entry_t;

endpackage

// File: rtl/if_entry_queue.sv
// rtl/if_entry_queue.sv - circular buffer of fetch entries with alloc/fill/read pointers
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   flush                    clear every entry and pointer
//   fault_push, fault_pc     with flush: leave a single filled fault entry (NOP)
//   alloc, alloc_pc          allocate tail entry as unfilled with this PC
//   fill, fill_instr         fill the oldest unfilled entry
//   pop                      retire the head entry
//   head                     entry at the read pointer
//   occupancy                allocated entries (filled or awaiting data)
//   unfilled                 allocated entries still awaiting data
module if_entry_queue
    import if_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     fault_push,
    input  logic [IF_XLEN-1:0]       fault_pc,
    input  logic                     alloc,
    input  logic [IF_XLEN-1:0]       alloc_pc,
    input  logic                     fill,
    input  logic [IF_XLEN-1:0]       fill_instr,
    input  logic                     pop,
    output if_entry_t                head,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [$clog2(DEPTH):0]   unfilled
);

    localparam int AW = $clog2(DEPTH);

    if_entry_t       mem [DEPTH];
    logic [AW:0]     wr_ptr;
    logic [AW:0]     fill_ptr;
    logic [AW:0]     rd_ptr;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign head      = mem[rd_ptr[AW-1:0]];
    assign occupancy = wr_ptr - rd_ptr;
    assign unfilled  = wr_ptr - fill_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            fill_ptr <= '0;
            rd_ptr   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            if (fault_push) begin
                mem[0]   <= '{pc: fault_pc, instr: NOP_INSTR, filled: 1'b1, misalign: 1'b1};
                wr_ptr   <= (AW+1)'(1);
                fill_ptr <= (AW+1)'(1);
            end else begin
                wr_ptr   <= '0;
                fill_ptr <= '0;
            end
        end else begin
            // Pop, fill and alloc never target the same slot: the credit
            // limit keeps alloc off a full queue, and pop needs a filled head.
            if (pop) begin
                mem[rd_ptr[AW-1:0]].filled   <= 1'b0;
                mem[rd_ptr[AW-1:0]].misalign <= 1'b0;
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
            if (fill && (unfilled != '0)) begin
                mem[fill_ptr[AW-1:0]].instr  <= fill_instr;
                mem[fill_ptr[AW-1:0]].filled <= 1'b1;
                fill_ptr <= fill_ptr + (AW+1)'(1);
            end
            if (alloc) begin
                mem[wr_ptr[AW-1:0]] <= '{pc: alloc_pc, instr: '0, filled: 1'b0, misalign: 1'b0};
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/instr_fetch_q.sv
// rtl/instr_fetch_q.sv - RV32 fetch stage: PC generation, credited imem requests, fetch queue
//
// Optional feature macro: IF_MISALIGN_CHECK_EN (misaligned redirect targets
// produce a single faulting NOP entry and halt fetch until the next redirect;
// when undefined, target bits [1:0] are forced to zero).
//
// Ports:
//   clk, rst                          clock, asynchronous active-low reset
//   branch_mem_if, PC_branch_mem_if   redirect request and target from MEM
//   imem_req, imem_addr, imem_gnt     request handshake toward instruction memory
//   imem_rvalid, imem_rdata           in-order response from instruction memory
//   valid_if_id, ready_id_if          head handshake toward decode
//   instr_if_id, PC_if_id             head instruction and its PC
//   exc_misalign_if_id                head carries a misaligned-target fault
module instr_fetch_q
    import if_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            branch_mem_if,
    input  logic [XLEN-1:0] PC_branch_mem_if,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            valid_if_id,
    input  logic            ready_id_if,
    output logic [XLEN-1:0] instr_if_id,
    output logic [XLEN-1:0] PC_if_id,
    output logic            exc_misalign_if_id
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] target;
    logic            started_q;
    logic            halt_q;
    logic            misalign_tgt;
    logic [CW-1:0]   discard_cnt;
    logic [CW-1:0]   occupancy;
    logic [CW-1:0]   unfilled;
    logic [CW-1:0]   alloc_cnt;
    logic            grant;
    logic            fill;
    logic            pop;
    if_entry_t       head;

`ifdef IF_MISALIGN_CHECK_EN
    assign target       = PC_branch_mem_if;
    assign misalign_tgt = branch_mem_if && (PC_branch_mem_if[1:0] != 2'b00);
`else
    assign target       = PC_branch_mem_if & ~XLEN'(3);
    assign misalign_tgt = 1'b0;
`endif

    // Every granted request owes one response: either to a queue entry or
    // to the discard counter, so their sum bounds outstanding traffic.
    assign alloc_cnt = occupancy + discard_cnt;
    assign imem_req  = started_q && !halt_q && !branch_mem_if && (alloc_cnt < CW'(DEPTH));
    assign imem_addr = pc_q;
    assign grant     = imem_req && imem_gnt;
    assign fill      = imem_rvalid && (discard_cnt == '0) && !branch_mem_if;

    // Gated by the redirect so nothing is consumed in that cycle.
    assign valid_if_id        = head.filled && !branch_mem_if;
    assign pop                = valid_if_id && ready_id_if;
    assign instr_if_id        = XLEN'(head.instr);
    assign PC_if_id           = XLEN'(head.pc);
    assign exc_misalign_if_id = head.filled && head.misalign;

    if_entry_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .flush      (branch_mem_if),
        .fault_push (misalign_tgt),
        .fault_pc   (IF_XLEN'(target)),
        .alloc      (grant),
        .alloc_pc   (IF_XLEN'(pc_q)),
        .fill       (fill),
        .fill_instr (IF_XLEN'(imem_rdata)),
        .pop        (pop),
        .head       (head),
        .occupancy  (occupancy),
        .unfilled   (unfilled)
    );

    // Requests start only after the first edge out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            started_q <= 1'b0;
        end else begin
            started_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= RESET_PC;
        end else if (branch_mem_if) begin
            pc_q <= target;
        end else if (grant) begin
            pc_q <= pc_q + XLEN'(PC_STEP);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            halt_q <= 1'b0;
        end else if (branch_mem_if) begin
            halt_q <= misalign_tgt;
        end
    end

    // On redirect, every response still owed (to earlier discards or to
    // unfilled entries) must be dropped, less the one arriving right now.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            discard_cnt <= '0;
        end else if (branch_mem_if) begin
            discard_cnt <= discard_cnt + unfilled - CW'(imem_rvalid);
        end else if (imem_rvalid && (discard_cnt != '0)) begin
            discard_cnt <= discard_cnt - CW'(1);
        end
    end

endmodule

// File: tb/tb_instr_fetch_q.sv
// tb/tb_instr_fetch_q.sv - scoreboard bench for instr_fetch_q
module tb_instr_fetch_q;

    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        branch_mem_if = 1'b0;
    logic [31:0] PC_branch_mem_if = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        valid_if_id;
    logic        ready_id_if = 1'b0;
    logic [31:0] instr_if_id;
    logic [31:0] PC_if_id;
    logic        exc_misalign_if_id;

    always #5 clk = ~clk;

    instr_fetch_q #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .branch_mem_if      (branch_mem_if),
        .PC_branch_mem_if   (PC_branch_mem_if),
        .imem_req           (imem_req),
        .imem_addr          (imem_addr),
        .imem_gnt           (imem_gnt),
        .imem_rvalid        (imem_rvalid),
        .imem_rdata         (imem_rdata),
        .valid_if_id        (valid_if_id),
        .ready_id_if        (ready_id_if),
        .instr_if_id        (instr_if_id),
        .PC_if_id           (PC_if_id),
        .exc_misalign_if_id (exc_misalign_if_id)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        exc;
    } exp_t;

    typedef struct {
        logic [31:0] data;
        int          due;
    } rsp_t;

    int          vectors     = 0;
    int          miscompares = 0;
    exp_t        exp_q[$];
    rsp_t        mem_q[$];
    logic [31:0] next_pc;
    bit          halted  = 1'b0;
    bit          mon_en  = 1'b0;
    int          cyc     = 0;
    int          grants  = 0;
    int          pops    = 0;
    int          gnt_pct = 100;
    int          lat_min = 1;
    int          lat_max = 1;
    exp_t        mon_e;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_A5A5;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Architectural expectation: after a redirect to T, decode sees T, T+4, ...
    task automatic top_up();
        while (!halted && exp_q.size() < 16) begin
            exp_q.push_back('{pc: next_pc, instr: mem_word(next_pc), exc: 1'b0});
            next_pc = next_pc + 32'd4;
        end
    endtask

    task automatic model_redirect(input logic [31:0] t);
        exp_q.delete();
`ifdef IF_MISALIGN_CHECK_EN
        if (t[1:0] != 2'b00) begin
            exp_q.push_back('{pc: t, instr: 32'h0000_0013, exc: 1'b1});
            halted = 1'b1;
            return;
        end
`endif
        halted  = 1'b0;
        next_pc = {t[31:2], 2'b00};
        top_up();
    endtask

    // One clock of stimulus: drive inputs after the falling edge, then
    // observe what the coming rising edge will do to the memory model.
    task automatic cycle(input bit br, input logic [31:0] tgt, input bit rdy);
        @(negedge clk);
        cyc++;
        branch_mem_if    = br;
        PC_branch_mem_if = tgt;
        ready_id_if      = rdy;
        imem_gnt         = ($urandom_range(99) < gnt_pct);
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_q[0].data;
            void'(mem_q.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        #1;
        if (imem_req && imem_gnt) begin
            grants++;
            check("imem_addr_aligned", {30'd0, imem_addr[1:0]}, 32'd0);
            mem_q.push_back('{data: mem_word(imem_addr), due: cyc + $urandom_range(lat_max, lat_min)});
        end
        if (halted && !br) check("imem_req_halted", {31'd0, imem_req}, 32'd0);
        if (br) model_redirect(tgt);
        top_up();
    endtask

    // Monitor: pops the scoreboard whenever decode consumes the head.
    always @(negedge clk) begin
        #2;
        if (mon_en) begin
            if (branch_mem_if) check("valid_gated_on_redirect", {31'd0, valid_if_id}, 32'd0);
            if (valid_if_id && ready_id_if) begin
                pops++;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_pop: got pc %08h expected none", PC_if_id);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("PC_if_id", PC_if_id, mon_e.pc);
                    check("instr_if_id", instr_if_id, mon_e.instr);
                    check("exc_misalign_if_id", {31'd0, exc_misalign_if_id}, {31'd0, mon_e.exc});
                end
            end
        end
    end

    initial begin
        int          p0;
        logic [31:0] tgt;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("reset_imem_req", {31'd0, imem_req}, 32'd0);
        check("reset_imem_addr", imem_addr, RESET_PC);
        check("reset_valid", {31'd0, valid_if_id}, 32'd0);
        check("reset_instr", instr_if_id, 32'd0);
        check("reset_pc", PC_if_id, 32'd0);
        check("reset_exc", {31'd0, exc_misalign_if_id}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("req_before_first_edge", {31'd0, imem_req}, 32'd0);
        halted  = 1'b0;
        next_pc = RESET_PC;
        top_up();
        mon_en  = 1'b1;

        // Back-pressure from reset release: exactly DEPTH grants then stall
        grants = 0;
        repeat (10) cycle(1'b0, 32'd0, 1'b0);
        check("bp_grants", grants, DEPTH);
        check("bp_req_stopped", {31'd0, imem_req}, 32'd0);
        check("bp_valid", {31'd0, valid_if_id}, 32'd1);
        check("bp_pc_held", PC_if_id, 32'd0);
        check("bp_instr_held", instr_if_id, mem_word(32'd0));

        // Resume at full rate
        p0 = pops;
        repeat (20) cycle(1'b0, 32'd0, 1'b1);
        check("throughput_ok", {31'd0, (pops - p0) >= 16}, 32'd1);

        // Zero-wait redirect latency, redirect coincides with pop and response
        cycle(1'b1, 32'h0000_0200, 1'b1);
        cycle(1'b0, 32'd0, 1'b1);
        check("redir_req", {31'd0, imem_req}, 32'd1);
        check("redir_addr", imem_addr, 32'h0000_0200);
        cycle(1'b0, 32'd0, 1'b1);
        cycle(1'b0, 32'd0, 1'b1);
        check("redir_valid", {31'd0, valid_if_id}, 32'd1);
        check("redir_pc", PC_if_id, 32'h0000_0200);
        repeat (6) cycle(1'b0, 32'd0, 1'b1);

        // Three-cycle memory, redirect with responses in flight
        lat_min = 3;
        lat_max = 3;
        repeat (6) cycle(1'b0, 32'd0, 1'b1);
        cycle(1'b1, 32'h0000_0100, 1'b1);
        p0 = pops;
        repeat (20) cycle(1'b0, 32'd0, 1'b1);
        check("lat3_progress", {31'd0, (pops - p0) >= 3}, 32'd1);

        // Address wrap
        lat_min = 1;
        lat_max = 1;
        cycle(1'b1, 32'hFFFF_FFF8, 1'b1);
        repeat (8) cycle(1'b0, 32'd0, 1'b1);

        // Misaligned target
        cycle(1'b1, 32'h0000_0102, 1'b1);
        repeat (8) cycle(1'b0, 32'd0, 1'b1);
        cycle(1'b1, 32'h0000_0300, 1'b1);
        repeat (4) cycle(1'b0, 32'd0, 1'b1);

        // Randomised traffic
        gnt_pct = 70;
        lat_min = 1;
        lat_max = 4;
        for (int i = 0; i < 2000; i++) begin
            tgt = $urandom;
            if ($urandom_range(3) != 0) tgt[1:0] = 2'b00;
            cycle($urandom_range(99) < 3, tgt, $urandom_range(99) < 70);
        end

        // Drain and liveness
        gnt_pct = 100;
        cycle(1'b1, 32'h0000_0400, 1'b1);
        p0 = pops;
        repeat (30) cycle(1'b0, 32'd0, 1'b1);
        check("drain_progress", {31'd0, (pops - p0) >= 10}, 32'd1);

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
